interval_timer: RTL



---
 rtl/nano6502_pkg.sv | 30 +++
 rtl/tick_divider.sv | 57 +++++
 rtl/interval_timer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/nano6502_pkg.sv
// Shared nano6502 peripheral definitions: I/O bank numbers, timer register map and bit fields.
package nano6502_pkg;

    localparam logic [7:0] IO_BANK_TIMER = 8'h05;

    localparam logic [3:0] TMR_CTRL     = 4'h0;
    localparam logic [3:0] TMR_STATUS   = 4'h1;
    localparam logic [3:0] TMR_RELOAD_L = 4'h2;
    localparam logic [3:0] TMR_RELOAD_H = 4'h3;
    localparam logic [3:0] TMR_COUNT_L  = 4'h4;
    localparam logic [3:0] TMR_COUNT_H  = 4'h5;
    localparam logic [3:0] TMR_PSC      = 4'h6;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_AUTO  = 1;
    localparam int unsigned CTRL_IE    = 2;
    localparam int unsigned STATUS_EXP = 0;

    // Field order makes bit 0 = EN, bit 1 = AUTO, bit 2 = IE.
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic en;
    } tmr_ctrl_t;

    function automatic logic [7:0] ctrl_to_byte(input tmr_ctrl_t c);
        return {5'b00000, c};
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running base divider followed by a programmable prescaler that emits cnt_tick_o.
module tick_divider #(
    parameter int unsigned CLK_DIV = 27,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned PSC_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [PSC_W-1:0] psc_i,
    output logic             cnt_tick_o
);

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_W-1:0] psc_act_q, psc_act_d;
    logic             base_tick;
    logic             psc_wrap;

    always_comb begin
        base_tick  = (div_q == DivLast);
        div_d      = base_tick ? '0 : div_q + 1'b1;
        psc_wrap   = (psc_cnt_q == psc_act_q);
        cnt_tick_o = en_i & base_tick & psc_wrap;

        psc_cnt_d = psc_cnt_q;
        psc_act_d = psc_act_q;
        // A new prescale value is only adopted at a wrap or restart so a running period is intact.
        if (clear_i) begin
            psc_cnt_d = '0;
            psc_act_d = psc_i;
        end else if (en_i && base_tick) begin
            if (psc_wrap) begin
                psc_cnt_d = '0;
                psc_act_d = psc_i;
            end else begin
                psc_cnt_d = psc_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q     <= '0;
            psc_cnt_q <= '0;
            psc_act_q <= '0;
        end else begin
            div_q     <= div_d;
            psc_cnt_q <= psc_cnt_d;
            psc_act_q <= psc_act_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable 16-bit countdown timer with auto-reload, snapshot read of COUNT_H and
// registered active-low interrupt.
module interval_timer
    import nano6502_pkg::*;
#(
    parameter int unsigned CLK_DIV = 27,
    parameter int unsigned DIV_W   = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cs_i,
    input  logic       R_W_n,
    input  logic [3:0] addr_i,
    input  logic [3:0] addr_w_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq_n_o
);

    tmr_ctrl_t   ctrl_q, ctrl_d;
    logic        exp_q, exp_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  psc_q, psc_d;
    logic [7:0]  snap_q, snap_d;
    logic        irq_n_q, irq_n_d;

    logic wr_en;
    logic rd_en;
    logic start;
    logic cnt_tick;
    logic expire;

    assign wr_en  = cs_i & ~R_W_n;
    assign rd_en  = cs_i & R_W_n;
    assign start  = wr_en && (addr_i == TMR_CTRL) && data_i[CTRL_EN] && !ctrl_q.en;
    assign expire = cnt_tick && (count_q == 16'h0000);

    tick_divider #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W),
        .PSC_W   (8)
    ) u_tick_divider (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (ctrl_q.en),
        .clear_i    (start),
        .psc_i      (psc_q),
        .cnt_tick_o (cnt_tick)
    );

    always_comb begin
        ctrl_d   = ctrl_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        count_d  = count_q;
        psc_d    = psc_q;
        snap_d   = snap_q;
        irq_n_d  = ~(exp_q & ctrl_q.ie);

        if (start) begin
            count_d = reload_q;
        end else if (cnt_tick) begin
            if (count_q == 16'h0000) begin
                if (ctrl_q.auto_rl) begin
                    count_d = reload_q;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                count_d = count_q - 16'd1;
            end
        end

        // CPU writes come after the expiry update so a CTRL write wins for EN.
        if (wr_en) begin
            case (addr_i)
                TMR_CTRL:     ctrl_d = tmr_ctrl_t'(data_i[2:0]);
                TMR_STATUS:   if (data_i[STATUS_EXP]) exp_d = 1'b0;
                TMR_RELOAD_L: reload_d[7:0] = data_i;
                TMR_RELOAD_H: reload_d[15:8] = data_i;
                TMR_PSC:      psc_d = data_i;
                default:      ;
            endcase
        end

        if (expire) begin
            exp_d = 1'b1;
        end

        if (rd_en && (addr_w_i == TMR_COUNT_L)) begin
            snap_d = count_q[15:8];
        end
    end

    always_comb begin
        data_o = 8'h00;
        if (rd_en) begin
            case (addr_w_i)
                TMR_CTRL:     data_o = ctrl_to_byte(ctrl_q);
                TMR_STATUS:   data_o = {7'b0000000, exp_q};
                TMR_RELOAD_L: data_o = reload_q[7:0];
                TMR_RELOAD_H: data_o = reload_q[15:8];
                TMR_COUNT_L:  data_o = count_q[7:0];
                TMR_COUNT_H:  data_o = snap_q;
                TMR_PSC:      data_o = psc_q;
                default:      data_o = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q   <= '0;
            exp_q    <= 1'b0;
            reload_q <= 16'hFFFF;
            count_q  <= 16'h0000;
            psc_q    <= 8'h00;
            snap_q   <= 8'h00;
            irq_n_q  <= 1'b1;
        end else begin
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            psc_q    <= psc_d;
            snap_q   <= snap_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign irq_n_o = irq_n_q;

endmodule
